// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle sequencer (master) and the RV32I datapath (slave).
interface multicycle_control_fsm_if;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic       InstrDone;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct3, Zero, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, InstrDone, Fault, State
    );

    modport slave (
        output Opcode, Funct3, Zero, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, InstrDone, Fault, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer with bounded memory waits and a sticky fault.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT instead of retiring them as NOPs.
module multicycle_control_fsm #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_fsm_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_JAL    = 4'd9,  S_JALR   = 4'd10, S_JALRPC  = 4'd11,
        S_BRANCH   = 4'd12, S_LUI    = 4'd13, S_AUIPC  = 4'd14, S_HALT    = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done;
    logic [1:0] src_a, src_b, alu_op, result_src;
    logic       mem_state, timeout, entering_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next state, wait counter and state-decoded controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;

        mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        timeout   = mem_state && !bus.MemReady && (cnt_q == CNT_W'(MAX_WAIT));

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.Opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_HALT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (bus.Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_JALR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = S_JALRPC;
            end
            S_JALRPC: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BRANCH: begin
                src_a    = 2'b10;
                alu_op   = 2'b01;
                pc_write = bus.Zero ^ bus.Funct3[0];
                state_d  = S_FETCH;
            end
            S_LUI: begin
                src_a   = 2'b11;
                src_b   = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                state_d = S_ALUWB;
            end
            S_HALT: state_d = S_HALT;
        endcase

        // A memory wait that runs out overrides the hold; MemReady on the last cycle still wins.
        if (timeout) state_d = S_HALT;
        if (state_d == S_HALT) fault_d = 1'b1;

        entering_mem = (state_d != state_q) &&
                       ((state_d == S_FETCH) || (state_d == S_MEMREAD) || (state_d == S_MEMWRITE));
        if (entering_mem) begin
            cnt_d = '0;
        end else if (mem_state && !bus.MemReady) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        instr_done = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_HALT);
    end

    // Reset masks every strobe and select in the same cycle so an aborted access never completes.
    assign bus.MemReq    = mem_req    & ~reset;
    assign bus.MemWrite  = mem_write  & ~reset;
    assign bus.AdrSrc    = adr_src    & ~reset;
    assign bus.IRWrite   = ir_write   & ~reset;
    assign bus.PCWrite   = pc_write   & ~reset;
    assign bus.RegWrite  = reg_write  & ~reset;
    assign bus.InstrDone = instr_done & ~reset;
    assign bus.ALUSrcA   = reset ? 2'b00 : src_a;
    assign bus.ALUSrcB   = reset ? 2'b00 : src_b;
    assign bus.ALUOp     = reset ? 2'b00 : alu_op;
    assign bus.ResultSrc = reset ? 2'b00 : result_src;
    assign bus.Fault     = fault_q;
    assign bus.State     = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-opcode state-path vectors, random instruction streams
// checked against a path model, and timeout / reset-abort / illegal-opcode corners.
module tb_multicycle_control_fsm;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;
`ifdef ILLEGAL_TRAP_EN
    localparam int NOPS = 9;
`else
    localparam int NOPS = 11;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed { logic [3:0] st; logic rdy; } step_t;
    typedef struct {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic            z;
        logic            pcw;
        int              len;
        logic [4:0][3:0] st;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] op_v = OP_RTYPE;
    logic [2:0] f3_v = 3'd0;
    logic       z_v  = 1'b0;
    step_t      path[$];
    vec_t       vt[$];
    logic [8:0] mux_tbl [16];
    logic [6:0] op_list [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.MemReq, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.InstrDone};
    endfunction

    function automatic logic [8:0] muxes();
        return {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc};
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input logic pcw, input int len,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.pcw = pcw; v.len = len;
        v.st[0] = 4'd0; v.st[1] = 4'd1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        return v;
    endfunction

    // One clock: drive inputs after the falling edge, let them settle before sampling.
    task automatic cyc(input logic rdy);
        @(negedge clk);
        reset        = 1'b0;
        bus.Opcode   = op_v;
        bus.Funct3   = f3_v;
        bus.Zero     = z_v;
        bus.MemReady = rdy;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset        = 1'b1;
            bus.Opcode   = op_v;
            bus.Funct3   = f3_v;
            bus.Zero     = z_v;
            bus.MemReady = 1'b1;
            #1;
            chk("reset_strobes", 32'(strobes()), 32'd0);
            chk("reset_muxes", 32'(muxes()), 32'd0);
        end
        chk("reset_state", 32'(bus.State), 32'd0);
        chk("reset_fault", 32'(bus.Fault), 32'd0);
    endtask

    task automatic push(input logic [3:0] s);
        path.push_back('{st: s, rdy: 1'($urandom)});
    endtask

    task automatic push_mem(input logic [3:0] s, input int waits);
        for (int i = 0; i < waits; i++) path.push_back('{st: s, rdy: 1'b0});
        path.push_back('{st: s, rdy: 1'b1});
    endtask

    // Expected state walk of one instruction, derived from its opcode class.
    task automatic build_path(input int k, input int wf, input int wm);
        path.delete();
        push_mem(4'd0, wf);
        push(4'd1);
        case (k)
            0: begin push(4'd2); push_mem(4'd3, wm); push(4'd4); end
            1: begin push(4'd2); push_mem(4'd5, wm); end
            2: begin push(4'd6); push(4'd8); end
            3: begin push(4'd7); push(4'd8); end
            4: begin push(4'd9); push(4'd8); end
            5: begin push(4'd10); push(4'd11); push(4'd8); end
            6: push(4'd12);
            7: begin push(4'd13); push(4'd8); end
            8: begin push(4'd14); push(4'd8); end
            default: ;
        endcase
    endtask

    task automatic run_path(input string nm);
        for (int i = 0; i < path.size(); i++) begin
            logic [3:0] s;
            logic       r;
            logic [5:0] exp;
            s = path[i].st;
            r = path[i].rdy;
            cyc(r);
            exp = {(s == 4'd0) || (s == 4'd3) || (s == 4'd5),
                   s == 4'd5,
                   (s == 4'd0) && r,
                   ((s == 4'd0) && r) || (s == 4'd9) || (s == 4'd11) || ((s == 4'd12) && (z_v ^ f3_v[0])),
                   (s == 4'd4) || (s == 4'd8),
                   i == path.size() - 1};
            chk({nm, "_state"}, 32'(bus.State), 32'(s));
            chk({nm, "_strobes"}, 32'(strobes()), 32'(exp));
            chk({nm, "_muxes"}, 32'(muxes()), 32'(mux_tbl[s]));
            chk({nm, "_fault"}, 32'(bus.Fault), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc} per state.
        mux_tbl[0]  = {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
        mux_tbl[1]  = {1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
        mux_tbl[2]  = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
        mux_tbl[3]  = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        mux_tbl[4]  = {1'b0, 2'b00, 2'b00, 2'b00, 2'b01};
        mux_tbl[5]  = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        mux_tbl[6]  = {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
        mux_tbl[7]  = {1'b0, 2'b10, 2'b01, 2'b10, 2'b00};
        mux_tbl[8]  = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        mux_tbl[9]  = {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
        mux_tbl[10] = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
        mux_tbl[11] = {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
        mux_tbl[12] = {1'b0, 2'b10, 2'b00, 2'b01, 2'b00};
        mux_tbl[13] = {1'b0, 2'b11, 2'b01, 2'b00, 2'b00};
        mux_tbl[14] = {1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
        mux_tbl[15] = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00};

        op_list[0] = OP_LOAD;   op_list[1] = OP_STORE; op_list[2] = OP_RTYPE;
        op_list[3] = OP_ITYPE;  op_list[4] = OP_JAL;   op_list[5] = OP_JALR;
        op_list[6] = OP_BRANCH; op_list[7] = OP_LUI;   op_list[8] = OP_AUIPC;
        op_list[9] = OP_BAD;    op_list[10] = 7'b0001111;

        vt.push_back(mk(OP_RTYPE,  3'b000, 1'b0, 1'b0, 4, 4'd6,  4'd8,  4'd0));
        vt.push_back(mk(OP_ITYPE,  3'b000, 1'b0, 1'b0, 4, 4'd7,  4'd8,  4'd0));
        vt.push_back(mk(OP_LOAD,   3'b010, 1'b0, 1'b0, 5, 4'd2,  4'd3,  4'd4));
        vt.push_back(mk(OP_STORE,  3'b010, 1'b0, 1'b0, 4, 4'd2,  4'd5,  4'd0));
        vt.push_back(mk(OP_JAL,    3'b000, 1'b0, 1'b0, 4, 4'd9,  4'd8,  4'd0));
        vt.push_back(mk(OP_JALR,   3'b000, 1'b0, 1'b0, 5, 4'd10, 4'd11, 4'd8));
        vt.push_back(mk(OP_BRANCH, 3'b000, 1'b1, 1'b1, 3, 4'd12, 4'd0,  4'd0));
        vt.push_back(mk(OP_BRANCH, 3'b001, 1'b1, 1'b0, 3, 4'd12, 4'd0,  4'd0));
        vt.push_back(mk(OP_BRANCH, 3'b000, 1'b0, 1'b0, 3, 4'd12, 4'd0,  4'd0));
        vt.push_back(mk(OP_BRANCH, 3'b001, 1'b0, 1'b1, 3, 4'd12, 4'd0,  4'd0));
        vt.push_back(mk(OP_LUI,    3'b000, 1'b0, 1'b0, 4, 4'd13, 4'd8,  4'd0));
        vt.push_back(mk(OP_AUIPC,  3'b000, 1'b0, 1'b0, 4, 4'd14, 4'd8,  4'd0));
`ifndef ILLEGAL_TRAP_EN
        vt.push_back(mk(OP_BAD,    3'b000, 1'b0, 1'b0, 2, 4'd0,  4'd0,  4'd0));
`endif

        do_reset();

        // Table vectors with MemReady held high.
        foreach (vt[v]) begin
            op_v = vt[v].op;
            f3_v = vt[v].f3;
            z_v  = vt[v].z;
            for (int i = 0; i < vt[v].len; i++) begin
                cyc(1'b1);
                chk($sformatf("vec%0d_state%0d", v, i), 32'(bus.State), 32'(vt[v].st[i]));
                chk($sformatf("vec%0d_mux%0d", v, i), 32'(muxes()), 32'(mux_tbl[vt[v].st[i]]));
                if (i == vt[v].len - 1) begin
                    chk($sformatf("vec%0d_pcwrite", v), 32'(bus.PCWrite), 32'(vt[v].pcw));
                    chk($sformatf("vec%0d_done", v), 32'(bus.InstrDone), 32'd1);
                end
            end
        end

        // Random instruction stream with random memory latency.
        for (int n = 0; n < 150; n++) begin
            int k;
            k    = int'($urandom_range(0, NOPS - 1));
            op_v = op_list[k];
            f3_v = 3'($urandom);
            z_v  = 1'($urandom);
            build_path(k, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            run_path($sformatf("rand%0d", n));
        end

        // Load with three wait cycles in MEMREAD.
        op_v = OP_LOAD;
        path.delete();
        push_mem(4'd0, 0); push(4'd1); push(4'd2); push_mem(4'd3, 3); push(4'd4);
        run_path("load_wait");

        // FETCH timeout: sixteen cycles without MemReady.
        do_reset();
        op_v = OP_RTYPE;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0);
            chk($sformatf("to_state%0d", i), 32'(bus.State), 32'd0);
            chk($sformatf("to_strobes%0d", i), 32'(strobes()), 32'b100000);
        end
        cyc(1'b1);
        chk("to_halt_state", 32'(bus.State), 32'd15);
        chk("to_halt_fault", 32'(bus.Fault), 32'd1);
        chk("to_halt_strobes", 32'(strobes()), 32'd0);
        repeat (3) cyc(1'b1);
        chk("to_halt_sticky", 32'(bus.State), 32'd15);

        // MemReady arriving exactly at the last allowed count.
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1'b0);
        cyc(1'b1);
        chk("edge_strobes", 32'(strobes()), 32'b101100);
        cyc(1'b1);
        chk("edge_state", 32'(bus.State), 32'd1);
        chk("edge_fault", 32'(bus.Fault), 32'd0);

        // Reset during a stalled store.
        do_reset();
        op_v = OP_STORE;
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        chk("abort_pre_state", 32'(bus.State), 32'd5);
        chk("abort_pre_strobes", 32'(strobes()), 32'b110000);
        @(negedge clk);
        reset        = 1'b1;
        bus.MemReady = 1'b0;
        #1;
        chk("abort_gate_strobes", 32'(strobes()), 32'd0);
        cyc(1'b0);
        chk("abort_state", 32'(bus.State), 32'd0);
        chk("abort_fault", 32'(bus.Fault), 32'd0);
        chk("abort_strobes", 32'(strobes()), 32'b100000);
        for (int i = 0; i < 14; i++) cyc(1'b0);
        cyc(1'b1);
        chk("abort_cnt_strobes", 32'(strobes()), 32'b101100);
        cyc(1'b1);
        chk("abort_cnt_state", 32'(bus.State), 32'd1);

`ifdef ILLEGAL_TRAP_EN
        // Unknown opcode traps into HALT.
        do_reset();
        op_v = OP_BAD;
        cyc(1'b1);
        cyc(1'b1);
        chk("trap_decode_strobes", 32'(strobes()), 32'd0);
        cyc(1'b1);
        chk("trap_state", 32'(bus.State), 32'd15);
        chk("trap_fault", 32'(bus.Fault), 32'd1);
        repeat (3) cyc(1'b1);
        chk("trap_sticky", 32'(bus.State), 32'd15);
`endif

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the RV32I core. Drives one shared ALU, one unified instruction/data memory, the register file and the PC/IR/ALUOut registers over 3-5 cycles per instruction.
- Reads Opcode (also routed to the immediate generator) and Funct3 from the instruction register.
- Handshakes with memory (MemReq/MemReady), bounds memory waits with a timeout, and reports faults and retirement.

Parameters:
- MAX_WAIT, 15: max consecutive cycles a memory state waits for MemReady before fault; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Opcode  in  7  instruction bits [6:0], stable from DECODE to end of instruction.
- Funct3  in  3  instruction bits [14:12].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  store strobe; valid only with MemReq.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  load the PC from Result.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  ALU operation: 00 = add, 01 = subtract, 10 = decode from funct fields.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- InstrDone  out  1  one-cycle retire pulse.
- Fault  out  1  sticky; set on memory timeout or trap.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset: synchronous. One clock and the reset port are fixed as above.
  - Edge with reset=1 gives State=FETCH(0), wait counter=0, Fault=0.
  - While reset=1, all strobes are forced to 0: MemReq, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone. Mux selects are 0.
- Outputs are Moore-decoded from State, except IRWrite, PCWrite and InstrDone, which also depend on MemReady/Zero in the same cycle. Unlisted outputs are 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, JALR=10, JALRPC=11, BRANCH=12, LUI=13, AUIPC=14, HALT=15.
- FETCH: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10.
  - On MemReady: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
- DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch/JAL target into ALUOut). Next state by Opcode:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR; 0010011 goes to EXECI.
  - 1101111 goes to JAL; 1100111 goes to JALR; 1100011 goes to BRANCH.
  - 0110111 goes to LUI; 0010111 goes to AUIPC.
  - Any other opcode: see Optional Feature.
- MEMADR: SrcA=10, SrcB=01, ALUOp=00. Goes to MEMREAD if Opcode=0000011, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Goes to MEMWB on MemReady.
- MEMWB: ResultSrc=01, RegWrite=1, goes to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Goes to FETCH on MemReady.
- EXECR: SrcA=10, SrcB=00, ALUOp=10, goes to ALUWB.
- EXECI: SrcA=10, SrcB=01, ALUOp=10, goes to ALUWB.
- LUI: SrcA=11, SrcB=01, ALUOp=00, goes to ALUWB.
- AUIPC: SrcA=01, SrcB=01, ALUOp=00, goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, goes to FETCH.
- JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, goes to ALUWB (link = OldPC+4).
- JALR: SrcA=10, SrcB=01, ALUOp=00, goes to JALRPC.
- JALRPC: SrcA=01, SrcB=10, ResultSrc=00, PCWrite=1, goes to ALUWB.
- BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, PCWrite = Zero XOR Funct3[0] (beq/bne). Goes to FETCH.
- HALT: all strobes 0, Fault=1. Leaves HALT only on reset.
- Retirement: InstrDone=1 on any transition into FETCH from a state other than FETCH or HALT.
- Memory wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle in those states while MemReady=0.
  - When count equals MAX_WAIT and MemReady=0: go to HALT, Fault set.
  - MemReady in that same cycle wins: normal transition, no fault.
- Reset mid-instruction aborts immediately. No partial write is issued after the reset edge.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE goes to HALT and sets Fault.
- ILLEGAL_TRAP_EN undefined: an unknown opcode goes to FETCH as a NOP. The PC is already advanced, InstrDone pulses, Fault stays 0.

Test Plan:
- reset for 2 cycles, then MemReady=1 constant, Opcode=0110011 -> State sequence 0,1,6,8,0; IRWrite and PCWrite high in FETCH; RegWrite high only in ALUWB; InstrDone pulses once per 4 cycles.
- Load with MemReady delayed 3 cycles in MEMREAD -> holds MemReq=1, AdrSrc=1 for 4 cycles; then MEMWB with ResultSrc=01, RegWrite=1; 5 states total plus waits.
- Branch Opcode=1100011: Funct3=000 with Zero=1 gives PCWrite=1; Funct3=001 with Zero=1 gives PCWrite=0; both return to FETCH.
- MemReady held 0 in FETCH with MAX_WAIT=15 -> State=15 and Fault=1 after 16 FETCH cycles; MemReady=1 exactly at count 15 gives DECODE and no fault.
- Opcode=1111111 -> with ILLEGAL_TRAP_EN: HALT, Fault=1, stays until reset. Without it: returns to FETCH, InstrDone=1, Fault=0.
- reset asserted during MEMWRITE with MemReady=0 -> next cycle State=0, MemWrite=0, Fault=0, counter cleared.
